// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: scheduler, operand-buffer and result-sink signals of the systolic sequencer
interface systolic_ctrl_if #(
    parameter int KW = 10,
    parameter int RW = 4
);
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          done;
    logic          arr_rstn;
    logic          arr_fire;
    logic          rd_en;
    logic [KW-1:0] rd_addr;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    modport master (
        output start, k_len, out_ready,
        input  busy, done, arr_rstn, arr_fire, rd_en, rd_addr, out_valid, out_row
    );
    modport slave (
        input  start, k_len, out_ready,
        output busy, done, arr_rstn, arr_fire, rd_en, rd_addr, out_valid, out_row
    );
endinterface

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: clears the PE array, streams K operand steps, waits out the drain, unloads result rows
module systolic_ctrl #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int KW     = 10,
    parameter int RD_LAT = 1,
    parameter int PE_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    systolic_ctrl_if.slave ctrl
);
    localparam int D  = RD_LAT + (ROWS - 1) + (COLS - 1) + PE_LAT;
    localparam int DW = $clog2(D + 1);
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, UNLOAD, DONE} state_t;
    state_t        state_q, state_d;
    logic [KW-1:0] k_q;
    logic [KW-1:0] step_q;
    logic [DW-1:0] drain_q;
    logic [RW-1:0] row_q;
    logic [RD_LAT-1:0] fire_q;
    logic          arr_rstn_q;
    logic          accept;
    logic          last_step;
    logic          beat;
    logic          last_beat;
    assign accept    = (state_q == IDLE || state_q == DONE) && ctrl.start;
    assign last_step = step_q == k_q - KW'(1);
    assign beat      = state_q == UNLOAD && ctrl.out_ready;
    assign last_beat = beat && row_q == RW'(ROWS - 1);
    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // Next-state: a zero-length reduction skips STREAM and drains an all-zero array
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = ctrl.start ? CLEAR : IDLE;
            CLEAR:      state_d = (k_q != '0) ? STREAM : DRAIN;
            STREAM:     state_d = last_step ? DRAIN : STREAM;
            DRAIN:      state_d = (drain_q == '0) ? UNLOAD : DRAIN;
            UNLOAD:     state_d = last_beat ? DONE : UNLOAD;
            default:    state_d = IDLE;
        endcase
    end
    // Step counter saturates at k_len-1 so the maximum length never wraps the address
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q        <= '0;
            step_q     <= '0;
            drain_q    <= '0;
            row_q      <= '0;
            arr_rstn_q <= 1'b0;
        end else begin
            if (accept) k_q <= ctrl.k_len;
            step_q     <= (state_q == STREAM) ? (last_step ? step_q : step_q + KW'(1)) : '0;
            drain_q    <= (state_q == DRAIN) ? drain_q - DW'(1) : DW'(D - 1);
            row_q      <= beat ? (last_beat ? '0 : row_q + RW'(1)) : row_q;
            arr_rstn_q <= state_d != CLEAR;
        end
    end
    // Fire strobe follows the read enable by the buffer read latency so it meets the data
    always_ff @(posedge clk) begin
        if (rst) begin
            fire_q <= '0;
        end else begin
            fire_q[0] <= state_q == STREAM;
            for (int i = 1; i < RD_LAT; i++) fire_q[i] <= fire_q[i-1];
        end
    end
    // Moore outputs decoded from the current state
    always_comb begin
        ctrl.busy      = state_q inside {CLEAR, STREAM, DRAIN, UNLOAD};
        ctrl.done      = state_q == DONE;
        ctrl.arr_rstn  = arr_rstn_q;
        ctrl.arr_fire  = fire_q[RD_LAT-1];
        ctrl.rd_en     = state_q == STREAM;
        ctrl.rd_addr   = (state_q == STREAM) ? step_q : '0;
        ctrl.out_valid = state_q == UNLOAD;
        ctrl.out_row   = row_q;
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: vector table, directed corner sequences and random traffic against a timeline model
module tb_systolic_ctrl;
    localparam int ROWS = 4, COLS = 4, KW = 4, RD_LAT = 1, PE_LAT = 1, RW = 2;
    localparam int D = RD_LAT + (ROWS - 1) + (COLS - 1) + PE_LAT;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    systolic_ctrl_if #(.KW(KW), .RW(RW)) bus ();
    systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .RD_LAT(RD_LAT), .PE_LAT(PE_LAT)) dut (
        .clk(clk), .rst(rst), .ctrl(bus)
    );
    typedef struct {
        logic          start;
        logic [KW-1:0] k_len;
        logic          ready;
        logic [11:0]   exp;
    } vec_t;
    vec_t tbl[19];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, c0, done_cyc, hs;
    logic s_busy, s_rstn, s_valid;
    logic [6:0] pat;
    // timeline model: cycles since acceptance, beats taken so far
    bit m_active = 0, m_done = 0, m_rstp = 1;
    int m_t = 0, m_k = 0, m_beats = 0;
    function automatic logic [11:0] pk(input logic b, input logic d, input logic n, input logic r,
                                       input logic f, input logic v, input int row, input int addr);
        return {b, d, n, r, f, v, RW'(row), KW'(addr)};
    endfunction
    function automatic logic [11:0] model_exp();
        logic rd, fire, valid;
        int ft;
        ft    = m_t - RD_LAT;
        rd    = m_active && m_t >= 2 && m_t <= m_k + 1;
        fire  = m_active && ft >= 2 && ft <= m_k + 1;
        valid = m_active && m_t >= m_k + 2 + D;
        return {m_active, m_done, !m_rstp && !(m_active && m_t == 1), rd, fire, valid,
                valid ? RW'(m_beats) : RW'(0), rd ? KW'(m_t - 2) : KW'(0)};
    endfunction
    task automatic model_step();
        if (rst) begin
            m_active = 0;
            m_done   = 0;
            m_rstp   = 1;
        end else begin
            m_rstp = 0;
            m_done = 0;
            if (m_active) begin
                if (m_t >= m_k + 2 + D && bus.out_ready) m_beats++;
                m_t++;
                if (m_beats == ROWS) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end else if (bus.start) begin
                m_active = 1;
                m_t      = 1;
                m_k      = int'(bus.k_len);
                m_beats  = 0;
            end
        end
    endtask
    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic tick(input bit use_tbl, input logic [11:0] texp);
        logic [11:0] act, mexp;
        @(negedge clk);
        act  = {bus.busy, bus.done, bus.arr_rstn, bus.rd_en, bus.arr_fire, bus.out_valid, bus.out_row, bus.rd_addr};
        mexp = model_exp();
        n_checks++;
        if (act !== mexp) begin
            n_fail++;
            $display("FAIL model cyc=%0d got %b expected %b (busy,done,rstn,rd_en,fire,valid,row,addr)", cyc, act, mexp);
        end
        if (use_tbl) begin
            n_checks++;
            if (act !== texp) begin
                n_fail++;
                $display("FAIL table cyc=%0d got %b expected %b", cyc, act, texp);
            end
        end
        if (bus.done === 1'b1) done_cyc = cyc;
        if (bus.out_valid === 1'b1 && bus.out_ready) hs++;
        s_busy  = bus.busy;
        s_rstn  = bus.arr_rstn;
        s_valid = bus.out_valid;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cyc < 0; i++) tick(0, '0);
    endtask
    task automatic run(input int k, input int lat, input string nm);
        int s;
        s = cyc;
        done_cyc = -1;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        tick(0, '0);
        bus.start = 1'b0;
        wait_done(100);
        chk(nm, done_cyc < 0 ? -1 : done_cyc - s, lat);
    endtask
    initial begin
        tbl[0]  = '{1'b1, KW'(3), 1'b1, pk(0, 0, 1, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b0, KW'(0), 1'b1, pk(1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{1'b0, KW'(0), 1'b1, pk(1, 0, 1, 1, 0, 0, 0, 0)};
        tbl[3]  = '{1'b0, KW'(0), 1'b1, pk(1, 0, 1, 1, 1, 0, 0, 1)};
        tbl[4]  = '{1'b0, KW'(0), 1'b1, pk(1, 0, 1, 1, 1, 0, 0, 2)};
        tbl[5]  = '{1'b0, KW'(0), 1'b1, pk(1, 0, 1, 0, 1, 0, 0, 0)};
        for (int i = 6; i <= 12; i++) tbl[i] = '{1'b0, KW'(0), 1'b1, pk(1, 0, 1, 0, 0, 0, 0, 0)};
        for (int i = 13; i <= 16; i++) tbl[i] = '{1'b0, KW'(0), 1'b1, pk(1, 0, 1, 0, 0, 1, i - 13, 0)};
        tbl[17] = '{1'b0, KW'(0), 1'b1, pk(0, 1, 1, 0, 0, 0, 0, 0)};
        tbl[18] = '{1'b0, KW'(0), 1'b1, pk(0, 0, 1, 0, 0, 0, 0, 0)};
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) tick(0, '0);
        chk("reset_rstn_low", int'(s_rstn), 0);
        chk("reset_busy_low", int'(s_busy), 0);
        rst = 1'b0;
        tick(0, '0);
        tick(0, '0);
        chk("rstn_after_release", int'(s_rstn), 1);
        c0 = cyc;
        done_cyc = -1;
        for (int i = 0; i < 19; i++) begin
            bus.start = tbl[i].start;
            bus.k_len = tbl[i].k_len;
            bus.out_ready = tbl[i].ready;
            tick(1, tbl[i].exp);
        end
        chk("nominal_done_cycle", done_cyc - c0, 17);
        run(0, 2 + D + ROWS, "k0_done_cycle");
        run((1 << KW) - 1, 2 + (1 << KW) - 1 + D + ROWS, "kmax_done_cycle");
        c0 = cyc;
        done_cyc = -1;
        hs = 0;
        pat = 7'b1001101;
        for (int i = 0; i < 23; i++) begin
            bus.start = (i == 0);
            bus.k_len = KW'(3);
            bus.out_ready = (i < 13) ? 1'b0 : (i < 20) ? pat[19-i] : 1'b1;
            tick(0, '0);
        end
        chk("backpressure_beats", hs, 4);
        chk("backpressure_done_cycle", done_cyc - c0, 20);
        c0 = cyc;
        done_cyc = -1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.start = (i == 0 || i == 6);
            bus.k_len = (i == 6) ? KW'(7) : KW'(3);
            tick(0, '0);
        end
        chk("busy_start_ignored_done", done_cyc - c0, 17);
        c0 = cyc;
        done_cyc = -1;
        for (int i = 0; i < 19; i++) begin
            bus.start = (i == 0 || i == 17);
            bus.k_len = (i == 17) ? KW'(2) : KW'(3);
            tick(0, '0);
            if (i == 18) begin
                chk("start_in_done_clear", int'(s_rstn), 0);
                chk("start_in_done_busy", int'(s_busy), 1);
            end
        end
        chk("first_run_done", done_cyc - c0, 17);
        bus.start = 1'b0;
        done_cyc = -1;
        wait_done(100);
        chk("restart_done_cycle", done_cyc - c0, 17 + 2 + 2 + D + ROWS);
        c0 = cyc;
        done_cyc = -1;
        for (int i = 0; i < 16; i++) begin
            bus.start = (i == 0);
            bus.k_len = KW'(3);
            rst = (i == 15);
            tick(0, '0);
        end
        rst = 1'b0;
        tick(0, '0);
        chk("rst_unload_busy", int'(s_busy), 0);
        chk("rst_unload_valid", int'(s_valid), 0);
        chk("rst_unload_rstn", int'(s_rstn), 0);
        repeat (4) tick(0, '0);
        chk("rst_unload_no_done", done_cyc, -1);
        run(1, 2 + 1 + D + ROWS, "post_rst_k1_done");
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.start = ($urandom_range(0, 5) == 0);
            bus.k_len = KW'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            tick(0, '0);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (2) tick(0, '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
